sap2_out_port: RTL and testbench
================================

Name: sap2_out_port

Overview:
- Receiving end of the SAP-2 CPU OUT instruction.
- Captures each byte the controller writes to output port 3 or 4 into a small FIFO.
- Presents the bytes one at a time on chip pins (uo_out plus one uio bit) using a four-phase valid/ack handshake with an external host.
- Sits between the top-level CPU instance and the pad wrapper, replacing the tied-off uo_out/uio_out.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
SYNC_STAGES, 2, flip-flops in the pin_ack synchronizer; minimum 2.

Ports:
CLK  input  1  system clock; all state on rising edge.
RST  input  1  asynchronous, active-high reset.
out_we  input  1  one-cycle strobe from the controller during OUT execution.
out_data  input  8  accumulator value to emit, valid with out_we.
out_sel  input  1  0 = port 3, 1 = port 4; stored with the byte.
clr_ovf  input  1  synchronous clear of the overflow flag.
fifo_full  output  1  FIFO holds DEPTH entries (combinational from count).
fifo_empty  output  1  FIFO holds 0 entries.
overflow  output  1  sticky; a write was dropped.
pin_data  output  8  byte presented to host (drives uo_out).
pin_port  output  1  port tag of pin_data.
pin_valid  output  1  handshake request to host.
pin_ack  input  1  host acknowledge, asynchronous to CLK.

Behaviour:
- Reset (asynchronous, RST=1):
  - FIFO count and pointers = 0; state = IDLE.
  - pin_data = 0, pin_port = 0, pin_valid = 0, overflow = 0.
  - All synchronizer flops = 0.
  - Outputs hold these values for as long as RST is asserted. Reset mid-handshake discards all queued bytes.
- FIFO:
  - Circular buffer of {sel, data}, 9 bits wide.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- Write rule: out_we=1 sampled at a rising edge.
  - Not full: the entry is stored at wr_ptr and wr_ptr increments.
  - Full, with a pop in the same cycle: the write is accepted.
  - Full, with no pop: the write is dropped and overflow is set to 1.
- overflow:
  - Cleared by RST or by clr_ovf=1.
  - If clr_ovf and a dropping write occur on the same edge, the set wins.
- pin_ack synchronizer: a chain of SYNC_STAGES flops produces ack_s. The FSM uses only ack_s.
- FSM (registered outputs):
  - IDLE: if not empty, load pin_data/pin_port from the FIFO head, set pin_valid=1, go to PRESENT. The head is not popped yet.
  - PRESENT: hold pin_valid=1 with pin_data stable. When ack_s=1, set pin_valid=0 and go to WAIT_LOW.
  - WAIT_LOW: when ack_s=0, pop the head (rd_ptr++, count--) and go to IDLE.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Latency:
  - Strobe sampled at edge E0 with the FIFO empty and in IDLE: pin_valid rises after E1.
  - After ack_s falls, the next queued byte's pin_valid rises 2 edges later (WAIT_LOW→IDLE, IDLE→PRESENT).
- pin_data and pin_port change only in IDLE on the load edge. They are never altered while pin_valid=1 or in WAIT_LOW.
- A host asserting pin_ack while in IDLE is ignored. A pin_ack that stays high causes no second transfer, because IDLE does not check ack and PRESENT needs a new 0→1 via WAIT_LOW.
- fifo_full and fifo_empty are derived from count, with no added latency.

Test Plan:
1. Assert RST asynchronously between clock edges → pin_valid, pin_data, overflow and fifo_empty read 0, 0, 0, 1 immediately; release, no strobes → outputs stay at reset values.
2. Single transfer: out_we with out_data=8'hA5, out_sel=1 at E0 → pin_valid=1, pin_data=8'hA5, pin_port=1 after E1. Host raises pin_ack → pin_valid=0 exactly SYNC_STAGES+1 edges later. Host drops pin_ack → fifo_empty=1 after SYNC_STAGES+1 edges.
3. Burst of 4 writes (8'h01..8'h04) on consecutive cycles, host slow → fifo_full=1, overflow=0. Host then completes 4 handshakes → pin_data sequence 01, 02, 03, 04 in order, then fifo_empty=1.
4. Fifth write of 8'hFF while full and host idle → overflow=1 and the FIFO contents are unchanged. Pulse clr_ovf → overflow=0. Repeat the drop with clr_ovf asserted on the same edge → overflow=1.
5. FIFO full in WAIT_LOW; out_we with 8'h55 on the edge where ack_s falls → the write is accepted, count stays 4, and 8'h55 is emitted last.
6. pin_ack held high from reset release; write 8'h3C → pin_valid rises, then falls 1 edge later, and no pop occurs until pin_ack goes low. Pointer wrap verified by 10 sequential transfers with values 0..9 emitted in order.

Source files
------------

// File: rtl/sap2_out_port.sv
// rtl/sap2_out_port.sv - SAP-2 OUT port capture FIFO with four-phase pin handshake
//
// Captures bytes written by the controller to port 3/4 into a DEPTH-entry FIFO
// and presents them one at a time to an external host on chip pins.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   out_we            one-cycle write strobe from the controller
//   out_data, out_sel byte to emit and its port tag (0 = port 3, 1 = port 4)
//   clr_ovf           synchronous clear of the sticky overflow flag
//   fifo_full/empty   FIFO occupancy flags, combinational from count
//   overflow          sticky flag, a write was dropped while full
//   pin_data/port     byte and port tag presented to the host
//   pin_valid         handshake request to the host
//   pin_ack           host acknowledge, asynchronous to CLK
module sap2_out_port #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       out_we,
    input  logic [7:0] out_data,
    input  logic       out_sel,
    input  logic       clr_ovf,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic [7:0] pin_data,
    output logic       pin_port,
    output logic       pin_valid,
    input  logic       pin_ack
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t state, state_n;

    logic [8:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   push;
    logic                   pop;
    logic [7:0]             data_n;
    logic                   port_n;
    logic                   valid_n;

    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    // A full FIFO still accepts a write on the cycle the head is popped.
    assign push       = out_we && (!fifo_full || pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], pin_ack};
        end
    end

    // Storage has no reset; only count and pointers define its contents.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {out_sel, out_data};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A dropped write outranks a same-edge clear.
            if (out_we && !push) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            pin_data  <= '0;
            pin_port  <= 1'b0;
            pin_valid <= 1'b0;
        end else begin
            state     <= state_n;
            pin_data  <= data_n;
            pin_port  <= port_n;
            pin_valid <= valid_n;
        end
    end

    // The head is only popped after the host has released ack, so a stuck-high
    // ack can never launch a second transfer.
    always_comb begin
        state_n = state;
        data_n  = pin_data;
        port_n  = pin_port;
        valid_n = pin_valid;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    {port_n, data_n} = mem[rd_ptr];
                    valid_n          = 1'b1;
                    state_n          = PRESENT;
                end
            end
            PRESENT: begin
                if (ack_s) begin
                    valid_n = 1'b0;
                    state_n = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    pop     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sap2_out_port.sv
// tb/tb_sap2_out_port.sv - scoreboard testbench for sap2_out_port
module tb_sap2_out_port;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       out_we = 1'b0;
    logic [7:0] out_data = '0;
    logic       out_sel = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       pin_ack = 1'b0;
    logic       fifo_full, fifo_empty, overflow, pin_port, pin_valid;
    logic [7:0] pin_data;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];

    sap2_out_port #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .out_we(out_we), .out_data(out_data),
        .out_sel(out_sel), .clr_ovf(clr_ovf), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .overflow(overflow), .pin_data(pin_data),
        .pin_port(pin_port), .pin_valid(pin_valid), .pin_ack(pin_ack)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic sel, input bit accept);
        out_data = d;
        out_sel  = sel;
        out_we   = 1'b1;
        step();
        out_we   = 1'b0;
        if (accept) sb.push_back({sel, d});
    endtask

    task automatic host_xfer(input string tag);
        int n;
        logic [8:0] exp;
        n = 0;
        while (!pin_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, pin_valid, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1ff;
        check({tag, "_data"}, pin_data, exp[7:0]);
        check({tag, "_port"}, pin_port, exp[8]);
        pin_ack = 1'b1;
        n = 0;
        while (pin_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_release"}, pin_valid, 0);
        pin_ack = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        int n;
        // 1: reset values, mid-cycle asynchronous reset
        step();
        step();
        RST = 1'b0;
        write_byte(8'h77, 1'b0, 1'b1);
        step();
        step();
        check("pre_reset_valid", pin_valid, 1);
        #3;
        RST = 1'b1;
        #1;
        check("rst_valid", pin_valid, 0);
        check("rst_data", pin_data, 8'h00);
        check("rst_ovf", overflow, 0);
        check("rst_empty", fifo_empty, 1);
        sb.delete();
        step();
        RST = 1'b0;
        step();
        step();
        step();
        check("idle_valid", pin_valid, 0);
        check("idle_empty", fifo_empty, 1);

        // 2: single transfer with latency checks
        write_byte(8'hA5, 1'b1, 1'b1);
        check("lat_e0_valid", pin_valid, 0);
        step();
        check("lat_e1_valid", pin_valid, 1);
        check("single_data", pin_data, 8'hA5);
        check("single_port", pin_port, 1);
        void'(sb.pop_front());
        pin_ack = 1'b1;
        n = 0;
        while (pin_valid && n < 20) begin
            step();
            n++;
        end
        check("ack_latency", n, 3);
        pin_ack = 1'b0;
        n = 0;
        while (!fifo_empty && n < 20) begin
            step();
            n++;
        end
        check("pop_latency", n, 3);

        // 3: burst to full
        for (int i = 1; i <= 4; i++) write_byte(8'(i), 1'b0, 1'b1);
        check("burst_full", fifo_full, 1);
        check("burst_ovf", overflow, 0);

        // 4: dropped write, clear, set-wins
        write_byte(8'hFF, 1'b1, 1'b0);
        check("drop_ovf", overflow, 1);
        check("drop_full", fifo_full, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_ovf", overflow, 0);
        clr_ovf = 1'b1;
        write_byte(8'hFF, 1'b0, 1'b0);
        clr_ovf = 1'b0;
        check("set_wins", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // 5: write on the pop edge while full is accepted
        check("head_valid", pin_valid, 1);
        check("head_data", pin_data, sb[0][7:0]);
        void'(sb.pop_front());
        pin_ack = 1'b1;
        n = 0;
        while (pin_valid && n < 20) begin
            step();
            n++;
        end
        pin_ack = 1'b0;
        step();
        step();
        write_byte(8'h55, 1'b0, 1'b1);
        check("popedge_full", fifo_full, 1);
        check("popedge_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) host_xfer($sformatf("drain%0d", i));
        check("drain_empty", fifo_empty, 1);

        // 6: ack held high across reset release
        pin_ack = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        step();
        step();
        write_byte(8'h3C, 1'b0, 1'b1);
        step();
        check("stuck_valid_hi", pin_valid, 1);
        check("stuck_data", pin_data, 8'h3C);
        step();
        check("stuck_valid_lo", pin_valid, 0);
        step();
        step();
        step();
        step();
        check("stuck_no_pop", fifo_empty, 0);
        check("stuck_no_repeat", pin_valid, 0);
        pin_ack = 1'b0;
        step();
        step();
        step();
        check("stuck_popped", fifo_empty, 1);
        void'(sb.pop_front());

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            write_byte(8'(i), i[0], 1'b1);
            host_xfer($sformatf("wrap%0d", i));
        end
        check("wrap_empty", fifo_empty, 1);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
